// File: rtl/and_share_pkg.sv
// and_share_pkg
//   Shared definitions for the and_share_arbiter slice:
//   - FSM state encodings (legacy 2-bit values kept for netlist compatibility)
//   - default requester count
//   - clog2 helper used to validate ID_W against NUM_REQ
package and_share_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned DEF_NUM_REQ = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/and_share_arbiter_if.sv
// and_share_arbiter_if
//   Request/response bundle between NUM_REQ requesters (plus one result
//   consumer) and the and_share_arbiter.
//   req_valid/req_a/req_b : per-requester request and operands (bit i = requester i)
//   req_ready             : one-hot grant/accept from the arbiter
//   rsp_valid/rsp_data/rsp_id : registered AND result and owning requester
//   rsp_ready             : consumer accepts the result
//   busy                  : arbiter is not idle
//   master = requester/consumer side, slave = arbiter side.
interface and_share_arbiter_if #(
   parameter int unsigned NUM_REQ = and_share_pkg::DEF_NUM_REQ,
   parameter int unsigned ID_W    = 2
);

   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_a;
   logic [NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0] req_ready;
   logic               rsp_valid;
   logic               rsp_data;
   logic [ID_W-1:0]    rsp_id;
   logic               rsp_ready;
   logic               busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

endinterface

// File: rtl/and_share_arbiter_and_cell.sv
// and_share_cell
//   Shared 2-input AND evaluation cell. Kept as its own hierarchical
//   instance so the netlist has a registered boundary on both sides of it;
//   in gate-level flows this body maps to a single AND2_X1.
//   a, b : operands (driven from the arbiter's operand registers)
//   y    : a & b
module and_share_cell (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a & b;

endmodule

// File: rtl/and_share_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   req_valid : request vector
//   rr_ptr    : requester with highest priority this cycle
//   grant     : one-hot, first set req_valid scanning upward from rr_ptr
//               with wrap at NUM_REQ; all zero when nothing is requested
//   gnt_idx   : binary index of the granted requester (0 when no grant)
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    gnt_idx
);

   logic            found;
   logic [ID_W-1:0] pos;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         pos = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            gnt_idx    = pos;
         end
      end
   end

endmodule

// File: rtl/and_share_arbiter.sv
// and_share_arbiter
//   Round-robin shares one AND cell among NUM_REQ requesters.
//   IDLE: grant one requester, register its operands.
//   EVAL: operands drive the shared cell; result is registered next edge.
//   RESP: tagged result held until rsp_ready, then back to IDLE.
//   Ports: clk, rst_n (async active-low), bus (and_share_arbiter_if.slave).
module and_share_arbiter
   import and_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   and_share_arbiter_if.slave   bus
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != clog2(NUM_REQ)) begin : g_param_check
      $error("and_share_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
   end

   logic [1:0]         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    id_q;
   logic               op_a;
   logic               op_b;
   logic               and_y;
   logic               rsp_valid_q;
   logic               rsp_data_q;
   logic [ID_W-1:0]    rsp_id_q;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    ptr_next;
   logic               xfer;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .gnt_idx   (gnt_idx)
   );

   and_share_cell u_and_cell (
      .a (op_a),
      .b (op_b),
      .y (and_y)
   );

   // rst_n gating keeps req_ready low for the whole reset window, not just
   // after the first edge.
   assign bus.req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
   assign xfer          = |(bus.req_valid & bus.req_ready);
   assign ptr_next      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         id_q        <= '0;
         op_a        <= 1'b0;
         op_b        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  op_a   <= bus.req_a[gnt_idx];
                  op_b   <= bus.req_b[gnt_idx];
                  id_q   <= gnt_idx;
                  rr_ptr <= ptr_next;
                  state  <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               rsp_data_q  <= and_y;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter
//   Directed self-checking bench for and_share_arbiter (NUM_REQ=4, ID_W=2).
//   Inputs change 1 time unit after a rising edge; outputs are checked
//   1-2 time units after the edge.
module tb_and_share_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   and_share_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

   and_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_a = 4'b1111;
      bus.req_b = 4'b1111;
      bus.rsp_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vectors++;
         if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
         end
         vectors++;
         if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
         end
         vectors++;
         if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
         end
      end
      vectors++;
      if (bus.rsp_data !== 1'b0 || bus.rsp_id !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_rsp_regs: got data=%b id=%0d expected data=0 id=0", bus.rsp_data, bus.rsp_id);
      end
      bus.req_valid = 4'b0000;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single();
      bus.req_valid = 4'b0100;
      bus.req_a = 4'b0100;
      bus.req_b = 4'b0100;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL single_grant: got %b expected 0100", bus.req_ready);
      end
      cyc();
      bus.req_valid = 4'b0000;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_eval: got ready=%b busy=%b rsp_valid=%b expected 0000 1 0",
                  bus.req_ready, bus.busy, bus.rsp_valid);
      end
      cyc();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 1'b1) begin
         miscompares++;
         $display("FAIL single_resp: got valid=%b id=%0d data=%b expected 1 2 1",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      end
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: got rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
      end
      // rr_ptr should now be 3: with everyone requesting, requester 3 wins.
      bus.req_valid = 4'b1111;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b1000) begin
         miscompares++;
         $display("FAIL single_rr_ptr: got %b expected 1000", bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      #1;
   endtask

   task automatic test_round_robin();
      logic [1:0] seq [5];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_a = 4'b1111;
      bus.req_b = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++;
         if (bus.req_ready !== (4'b0001 << seq[k])) begin
            miscompares++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, 4'b0001 << seq[k]);
         end
         cyc();
         vectors++;
         if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_eval_ready[%0d]: got %b expected 0000", k, bus.req_ready);
         end
         cyc();
         vectors++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== seq[k] || bus.rsp_data !== 1'b1 ||
             bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_resp[%0d]: got valid=%b id=%0d data=%b ready=%b expected 1 %0d 1 0000",
                     k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, seq[k]);
         end
         cyc();
      end
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      #1;
   endtask

   task automatic test_truth_table();
      logic [3:0] exp_tt;
      logic [1:0] ab;
      exp_tt = 4'b1000;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ab = 2'(k);
         // Neighbouring operand bits set to 1 so a wrong bit select shows up.
         bus.req_a = 4'b1101;
         bus.req_b = 4'b1101;
         bus.req_a[1] = ab[1];
         bus.req_b[1] = ab[0];
         bus.req_valid = 4'b0010;
         #1;
         vectors++;
         if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL tt_grant[%0d]: got %b expected 0010", k, bus.req_ready);
         end
         cyc();
         bus.req_valid = 4'b0000;
         cyc();
         vectors++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== exp_tt[k]) begin
            miscompares++;
            $display("FAIL tt_resp[a=%b b=%b]: got valid=%b id=%0d data=%b expected 1 1 %b",
                     ab[1], ab[0], bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_tt[k]);
         end
         cyc();
      end
      bus.rsp_ready = 1'b0;
      #1;
   endtask

   task automatic test_backpressure();
      bus.req_valid = 4'b0001;
      bus.req_a = 4'b1111;
      bus.req_b = 4'b1111;
      bus.rsp_ready = 1'b0;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL bp_grant: got %b expected 0001", bus.req_ready);
      end
      cyc();
      bus.req_valid = 4'b1111;
      cyc();
      bus.req_a = 4'b0000;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 1'b1 || bus.rsp_id !== 2'd0) begin
         miscompares++;
         $display("FAIL bp_resp: got valid=%b data=%b id=%0d expected 1 1 0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
         vectors++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 1'b1 || bus.rsp_id !== 2'd0 ||
             bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%b id=%0d ready=%b busy=%b expected 1 1 0 0000 1",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, bus.busy);
         end
      end
      bus.rsp_ready = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL bp_accept_ready: got %b expected 0000", bus.req_ready);
      end
      cyc();
      bus.rsp_ready = 1'b0;
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL bp_release: got valid=%b ready=%b expected 0 0010", bus.rsp_valid, bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      bus.req_a = 4'b0000;
      bus.req_b = 4'b0000;
      #1;
   endtask

   task automatic test_reset_in_eval();
      bus.req_valid = 4'b1000;
      bus.req_a = 4'b1000;
      bus.req_b = 4'b1000;
      bus.rsp_ready = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b1000) begin
         miscompares++;
         $display("FAIL rst_eval_grant: got %b expected 1000", bus.req_ready);
      end
      cyc();
      bus.req_valid = 4'b0000;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL rst_eval_abort: got busy=%b valid=%b ready=%b expected 0 0 0000",
                  bus.busy, bus.rsp_valid, bus.req_ready);
      end
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vectors++;
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_eval_no_replay[%0d]: got valid=%b busy=%b expected 0 0",
                     i, bus.rsp_valid, bus.busy);
         end
      end
      bus.req_valid = 4'b0110;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL rst_eval_next_grant: got %b expected 0010", bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset_in_resp();
      // Grant requester 1 (rr_ptr -> 2), then reset while the result is held.
      bus.req_valid = 4'b0010;
      bus.req_a = 4'b1111;
      bus.req_b = 4'b1111;
      bus.rsp_ready = 1'b0;
      #1;
      cyc();
      bus.req_valid = 4'b0000;
      cyc();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin
         miscompares++;
         $display("FAIL rst_resp_setup: got valid=%b id=%0d expected 1 1", bus.rsp_valid, bus.rsp_id);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 1'b0 || bus.rsp_id !== 2'd0) begin
         miscompares++;
         $display("FAIL rst_resp_drop: got valid=%b data=%b id=%0d expected 0 0 0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      rst_n = 1'b1;
      #1;
      bus.req_valid = 4'b1111;
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL rst_resp_ptr: got %b expected 0001", bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      cyc();
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_resp_idle: got valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_truth_table();
      test_backpressure();
      test_reset_in_eval();
      test_reset_in_resp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/and_share_arbiter.md
Name: and_share_arbiter

Overview:
- Shares one hierarchical 2-input AND evaluation cell (an AND2_X1 wrapped in a child module) among NUM_REQ requesters.
- Grants round-robin, registers the operands, drives the shared cell, then holds a tagged registered result until the consumer accepts it.
- Sits above the inverter/AND datapath in hierarchical netlist tests, so the timer sees sequential start and end points around a hierarchy boundary.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ  per-requester operand A; bit i belongs to requester i.
- req_b  input  NUM_REQ  per-requester operand B.
- req_ready  output  NUM_REQ  one-hot grant/accept; combinational from state and req_valid.
- rsp_valid  output  1  result valid.
- rsp_data  output  1  registered AND result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, rr_ptr=0.
  - op_a=op_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready=0 while rst_n is low.
- States: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid is set, req_ready asserts for exactly one requester g. g is the first set req_valid scanning from rr_ptr upward, wrapping at NUM_REQ.
  - A transfer happens on a clock edge where req_valid[g] and req_ready[g] are both high. At that edge: op_a<=req_a[g], op_b<=req_b[g], id<=g, rr_ptr<=(g+1) mod NUM_REQ, state<=EVAL.
  - With no req_valid set, req_ready=0 and the state stays IDLE.
- EVAL:
  - op_a and op_b drive the shared AND child cell.
  - Next edge: rsp_data<=cell output, rsp_id<=id, rsp_valid<=1, state<=RESP.
  - req_ready=0.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until the edge where rsp_ready=1.
  - At that edge: rsp_valid<=0, state<=IDLE.
  - req_ready=0; no back-to-back overlap.
- Latency: grant edge to rsp_valid high is 2 cycles. Minimum issue interval is 3 cycles when rsp_ready is held high.
- rr_ptr advances only on a grant, never on idle cycles.
- Requester rules:
  - A requester may not drop req_valid before it is granted.
  - The arbiter must not depend on that rule; it re-evaluates the grant every IDLE cycle.
- rsp_ready while not in RESP is ignored.
- Asynchronous reset mid-EVAL or mid-RESP discards the operation. rsp_valid falls immediately and no result is replayed after release.
- rst_n release is synchronised by the surrounding test harness; the block needs no internal synchroniser.
- rr_ptr wraps from NUM_REQ-1 to 0. With a non-power-of-two NUM_REQ, values at or above NUM_REQ are unreachable.
- busy = (state != IDLE).

Decomposition:
- Package and_share_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_EVAL=2'd1, ST_RESP=2'd2;
  - the default NUM_REQ;
  - a clog2 function for ID_W checking.
- Sub-module rr_pick (combinational): inputs req_valid and rr_ptr; outputs a one-hot grant and a binary index.
- The shared AND cell stays a separate hierarchical instance, so dbSta hierarchy traversal covers a registered boundary.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0 throughout.
- Single request: req_valid=4'b0100, req_a[2]=1, req_b[2]=1 -> req_ready=4'b0100 in the grant cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data=1; rr_ptr=3 afterwards.
- Round-robin fairness: all four req_valid held high, rsp_ready=1, all operand bits 1 -> grants in order 0,1,2,3,0; one grant every 3 cycles; each rsp_data=1.
- Operand truth table on requester 1: (a,b) = (0,0), (0,1), (1,0), (1,1) -> rsp_data = 0, 0, 0, 1 respectively, each with rsp_id=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_data and rsp_id stay constant; req_ready=0; a new grant occurs only after the rsp_ready edge.
- Reset in EVAL: assert rst_n=0 one cycle after a grant to requester 3 -> rsp_valid never rises; after release, rr_ptr=0 and the next grant goes to the lowest-index valid requester.
